pkt_out_buf: RTL and testbench
==============================

Name: pkt_out_buf

Overview:
- Packet store-and-forward buffer directly downstream of the user module (um); consumes its pktout_* stream (134-bit flits plus a per-packet valid flag) and presents whole, validated packets to the output port/DMA side.
- Drops packets flagged invalid at the tail by rewinding the write pointer. Provides ready-based backpressure to um, evaluated at packet boundaries.

Parameters:
- DATA_AW, 8, data FIFO address width (depth 2^DATA_AW flits).
- DESC_AW, 4, packet descriptor FIFO address width (2^DESC_AW committed packets).
- MAX_PKT_FLITS, 96, worst-case flits per packet; sets in_ready headroom.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_data_wr  in  1  flit write strobe from um.
- in_data  in  134  flit; [133:132] 01=head, 11=middle, 10=tail; [131:128] carried through untouched; [127:0] payload.
- in_data_valid_wr  in  1  packet-valid strobe; coincident with the tail flit.
- in_data_valid  in  1  1=keep packet, 0=drop.
- in_ready  out  1  um may start a new packet.
- out_data_wr  out  1  flit strobe.
- out_data  out  134  flit, bit-identical to input.
- out_data_valid_wr  out  1  asserted with the tail flit.
- out_data_valid  out  1  always 1 when out_data_valid_wr=1.
- out_ready  in  1  downstream can accept a full packet; sampled only at packet start.

Behaviour:
- Reset: all outputs 0 except in_ready=1; all pointers, counts and FSMs cleared. Reset mid-packet discards everything, including committed packets.
- Write side: speculative pointer wr_ptr, committed pointer wr_commit, pkt_start latch. All pointers are DATA_AW+1 bits wide and wrap modulo 2^(DATA_AW+1).
- Write-side flit handling:
  - Head flit: latch pkt_start=wr_ptr and write it; set in_pkt.
  - Middle flit: write only if in_pkt.
  - Tail flit: write only if in_pkt.
  - Middle/tail flit with in_pkt=0: discard silently.
- Head while in_pkt=1 (missing tail): rewind wr_ptr to pkt_start, then store the new head at pkt_start.
- Tail with in_data_valid_wr=1:
  - in_data_valid=1 and no overflow: push descriptor {start, end}; wr_commit=wr_ptr+1 (next cycle).
  - Otherwise: wr_ptr<=pkt_start.
  - Tail without in_data_valid_wr is treated as in_data_valid=0.
- Overflow: a flit write when the data FIFO is full (wr_ptr-rd_ptr==2^DATA_AW) is not stored and sets err; the packet is dropped at its tail. If the descriptor FIFO is full at tail, the packet is also dropped.
- in_ready, registered: 1 iff (2^DATA_AW - (wr_ptr-rd_ptr)) >= MAX_PKT_FLITS and desc_count < 2^DESC_AW - 1.
- Read FSM:
  - IDLE: go to SEND when desc_count>0 and out_ready=1; pop the descriptor and issue the RAM read of start.
  - SEND: issue one read per cycle until the end address. out_ready is ignored until the tail.
  - Tail-flit read: rd_ptr=end+1; go to IDLE.
- Read timing: RAM read latency is 1 cycle, and out_* are registered. Back-to-back packets have one IDLE bubble cycle.
- Latency: tail written at cycle T → committed at T+1 → first out_data_wr no earlier than T+3.
- Simultaneous commit and pop: desc_count unchanged. Read and write to the same address cannot occur (committed data only).

Optional Feature:
- PKT_OUT_BUF_STAT_EN defined: adds 32-bit wrapping output counters stat_rx_pkt, stat_drop_pkt, stat_tx_pkt, plus input stat_clr (sync clear; clear wins over increment).
- Undefined: ports and logic absent.

Decomposition:
- Package pkt_buf_pkg: FLIT_W=134, HDR_HEAD=2'b01, HDR_MID=2'b11, HDR_TAIL=2'b10, read FSM state enum.
- Sub-module sdp_ram (simple dual-port, 1-cycle registered read), instantiated twice: data store and descriptor store.

Test Plan:
- Single 9-flit packet (head, middle carrying 16'h86dd at [31:16], 6 middle, tail), valid=1, out_ready=1 → 9 identical flits out; out_data_valid_wr=out_data_valid=1 on flit 9 only; first out flit 3 cycles after tail.
- Same packet with in_data_valid=0 → no output; wr_ptr returns to 0; a subsequent valid packet appears starting at address 0.
- out_ready=0, stream 9-flit valid packets (DATA_AW=8, MAX_PKT_FLITS=96) → in_ready falls after the 18th packet (162 flits used); raise out_ready → 18 packets out in order; in_ready returns to 1.
- Head, 3 middles, then a new head with no tail → first partial packet never emitted; second packet emitted intact.
- Reset asserted mid-SEND → next cycle all out_* = 0, in_ready=1, desc_count=0.
- With PKT_OUT_BUF_STAT_EN: 3 valid and 1 dropped packets → rx=4, drop=1, tx=3; stat_clr → all 0.

Source files
------------

// File: rtl/pkt_buf_pkg.sv
// Shared constants and read-FSM state type for the packet output buffer.
package pkt_buf_pkg;

    localparam int FLIT_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_MID  = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered (1-cycle) read.
module sdp_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/pkt_out_buf.sv
// Store-and-forward packet buffer behind the user module; drops bad packets by rewinding
// the write pointer. Optional counters are enabled by defining PKT_OUT_BUF_STAT_EN.
module pkt_out_buf
    import pkt_buf_pkg::*;
#(
    parameter int DATA_AW       = 8,
    parameter int DESC_AW       = 4,
    parameter int MAX_PKT_FLITS = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_data_wr,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_data_valid_wr,
    input  logic              in_data_valid,
    output logic              in_ready,
    output logic              out_data_wr,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_data_valid_wr,
    output logic              out_data_valid,
    input  logic              out_ready
`ifdef PKT_OUT_BUF_STAT_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_rx_pkt,
    output logic [31:0]       stat_drop_pkt,
    output logic [31:0]       stat_tx_pkt
`endif
);

    localparam int PW         = DATA_AW + 1;
    localparam int DESC_DEPTH = 1 << DESC_AW;
    localparam logic [PW-1:0]      FULL_LVL  = PW'(1 << DATA_AW);
    localparam logic [PW-1:0]      MAX_LVL   = PW'(MAX_PKT_FLITS);
    localparam logic [DESC_AW:0]   DESC_FULL = (DESC_AW+1)'(DESC_DEPTH);
    localparam logic [DESC_AW:0]   DESC_HI   = (DESC_AW+1)'(DESC_DEPTH - 1);

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
    logic [PW-1:0]      pkt_start_q, pkt_start_d, rd_ptr_q, base;
    logic               in_pkt_q, in_pkt_d, err_q, err_d;
    logic               in_ready_q, wr_full, head_full, desc_full;
    logic [1:0]         hdr;
    logic               data_we, desc_we;
    logic [DATA_AW-1:0] data_waddr;
    logic [FLIT_W-1:0]  data_rdata;
    logic [2*PW-1:0]    desc_wdata, desc_rdata;
    logic [DESC_AW:0]   desc_count_q;
    logic [DESC_AW-1:0] desc_wr_q, desc_rd_q;

    rd_state_e          rd_state_q;
    logic               first_q, rd_en_q, rd_tail_q, rd_pop;
    logic [PW-1:0]      cur_addr_q, end_q, rd_addr, rd_end;
    logic               out_wr_q, out_vwr_q, out_v_q;
    logic [FLIT_W-1:0]  out_data_q;

    assign hdr        = in_data[FLIT_W-1 -: 2];
    // Outside a packet the speculative pointer always sits on the commit point.
    assign base       = in_pkt_q ? pkt_start_q : wr_commit_q;
    assign wr_full    = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign head_full  = (base - rd_ptr_q) == FULL_LVL;
    assign desc_full  = desc_count_q == DESC_FULL;
    assign desc_wdata = {pkt_start_q, wr_ptr_q};

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        pkt_start_d = pkt_start_q;
        in_pkt_d    = in_pkt_q;
        err_d       = err_q;
        data_we     = 1'b0;
        data_waddr  = wr_ptr_q[DATA_AW-1:0];
        desc_we     = 1'b0;
        if (in_data_wr) begin
            case (hdr)
                HDR_HEAD: begin
                    pkt_start_d = base;
                    in_pkt_d    = 1'b1;
                    data_waddr  = base[DATA_AW-1:0];
                    data_we     = !head_full;
                    err_d       = head_full;
                    wr_ptr_d    = head_full ? base : base + 1'b1;
                end
                HDR_MID: begin
                    if (in_pkt_q) begin
                        if (wr_full) begin
                            err_d = 1'b1;
                        end else begin
                            data_we  = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                HDR_TAIL: begin
                    if (in_pkt_q) begin
                        in_pkt_d = 1'b0;
                        err_d    = 1'b0;
                        if (!wr_full && !err_q && !desc_full && in_data_valid_wr && in_data_valid) begin
                            data_we     = 1'b1;
                            desc_we     = 1'b1;
                            wr_ptr_d    = wr_ptr_q + 1'b1;
                            wr_commit_d = wr_ptr_q + 1'b1;
                        end else begin
                            wr_ptr_d = pkt_start_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            pkt_start_q  <= '0;
            in_pkt_q     <= 1'b0;
            err_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            desc_count_q <= '0;
            desc_wr_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            pkt_start_q <= pkt_start_d;
            in_pkt_q    <= in_pkt_d;
            err_q       <= err_d;
            in_ready_q  <= ((FULL_LVL - (wr_ptr_q - rd_ptr_q)) >= MAX_LVL) && (desc_count_q < DESC_HI);
            if (desc_we) begin
                desc_wr_q <= desc_wr_q + 1'b1;
            end
            case ({desc_we, rd_pop})
                2'b10:   desc_count_q <= desc_count_q + 1'b1;
                2'b01:   desc_count_q <= desc_count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // The descriptor RAM reads the queue head continuously, so it is valid in the first SEND cycle.
    assign rd_pop  = (rd_state_q == RD_IDLE) && (desc_count_q != '0) && out_ready;
    assign rd_addr = first_q ? desc_rdata[2*PW-1:PW] : cur_addr_q;
    assign rd_end  = first_q ? desc_rdata[PW-1:0] : end_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            first_q    <= 1'b0;
            cur_addr_q <= '0;
            end_q      <= '0;
            rd_ptr_q   <= '0;
            desc_rd_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_tail_q  <= 1'b0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_vwr_q  <= 1'b0;
            out_v_q    <= 1'b0;
        end else begin
            first_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_tail_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_pop) begin
                        rd_state_q <= RD_SEND;
                        first_q    <= 1'b1;
                        desc_rd_q  <= desc_rd_q + 1'b1;
                    end
                end
                RD_SEND: begin
                    rd_en_q    <= 1'b1;
                    cur_addr_q <= rd_addr + 1'b1;
                    end_q      <= rd_end;
                    if (rd_addr == rd_end) begin
                        rd_tail_q  <= 1'b1;
                        rd_ptr_q   <= rd_end + 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
            out_wr_q   <= rd_en_q;
            out_data_q <= rd_en_q ? data_rdata : '0;
            out_vwr_q  <= rd_tail_q;
            out_v_q    <= rd_tail_q;
        end
    end

    sdp_ram #(.AW(DATA_AW), .DW(FLIT_W)) u_data_ram (
        .clk_i   (clk),
        .we_i    (data_we),
        .waddr_i (data_waddr),
        .wdata_i (in_data),
        .re_i    (rd_state_q == RD_SEND),
        .raddr_i (rd_addr[DATA_AW-1:0]),
        .rdata_o (data_rdata)
    );

    sdp_ram #(.AW(DESC_AW), .DW(2*PW)) u_desc_ram (
        .clk_i   (clk),
        .we_i    (desc_we),
        .waddr_i (desc_wr_q),
        .wdata_i (desc_wdata),
        .re_i    (1'b1),
        .raddr_i (desc_rd_q),
        .rdata_o (desc_rdata)
    );

    assign in_ready          = in_ready_q;
    assign out_data_wr       = out_wr_q;
    assign out_data          = out_data_q;
    assign out_data_valid_wr = out_vwr_q;
    assign out_data_valid    = out_v_q;

`ifdef PKT_OUT_BUF_STAT_EN
    logic        pkt_rx, pkt_drop;
    logic [31:0] stat_rx_q, stat_drop_q, stat_tx_q;

    // A packet is resolved at its tail, or when a fresh head abandons it.
    assign pkt_rx   = in_data_wr && in_pkt_q && ((hdr == HDR_HEAD) || (hdr == HDR_TAIL));
    assign pkt_drop = pkt_rx && !desc_we;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_rx_q   <= '0;
            stat_drop_q <= '0;
            stat_tx_q   <= '0;
        end else begin
            if (pkt_rx)    stat_rx_q   <= stat_rx_q + 1'b1;
            if (pkt_drop)  stat_drop_q <= stat_drop_q + 1'b1;
            if (rd_tail_q) stat_tx_q   <= stat_tx_q + 1'b1;
        end
    end

    assign stat_rx_pkt   = stat_rx_q;
    assign stat_drop_pkt = stat_drop_q;
    assign stat_tx_pkt   = stat_tx_q;
`endif

endmodule

// File: tb/tb_pkt_out_buf.sv
// Bench for pkt_out_buf: directed packet scenarios plus randomized traffic against a packet-level model.
module tb_pkt_out_buf;

  localparam logic [1:0] H_HEAD = 2'b01;
  localparam logic [1:0] H_MID  = 2'b11;
  localparam logic [1:0] H_TAIL = 2'b10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_data_wr, in_data_valid_wr, in_data_valid, in_ready;
  logic [133:0] in_data;
  logic         out_data_wr, out_data_valid_wr, out_data_valid, out_ready;
  logic [133:0] out_data;
`ifdef PKT_OUT_BUF_STAT_EN
  logic         stat_clr;
  logic [31:0]  stat_rx_pkt, stat_drop_pkt, stat_tx_pkt;
`endif

  pkt_out_buf #(.DATA_AW(8), .DESC_AW(5), .MAX_PKT_FLITS(96)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_data_wr        (in_data_wr),
    .in_data           (in_data),
    .in_data_valid_wr  (in_data_valid_wr),
    .in_data_valid     (in_data_valid),
    .in_ready          (in_ready),
    .out_data_wr       (out_data_wr),
    .out_data          (out_data),
    .out_data_valid_wr (out_data_valid_wr),
    .out_data_valid    (out_data_valid),
    .out_ready         (out_ready)
`ifdef PKT_OUT_BUF_STAT_EN
    ,
    .stat_clr          (stat_clr),
    .stat_rx_pkt       (stat_rx_pkt),
    .stat_drop_pkt     (stat_drop_pkt),
    .stat_tx_pkt       (stat_tx_pkt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [133:0] exp_q[$];
  bit           exp_last_q[$];
  int           mdl_len_q[$];
  int           n_asrt = 0;
  int           n_fail = 0;
  int           out_cnt = 0;
  int           first_cyc = 0;
  int           tail_cyc = 0;
  bit           rand_or = 1'b0;

  task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_ready();
    int used = 0;
    foreach (mdl_len_q[i]) used += mdl_len_q[i];
    return ((256 - used) >= 96) && (mdl_len_q.size() < 31);
  endfunction

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_data_wr) begin
      logic [133:0] e;
      bit           l;
      out_cnt++;
      if (out_data[133:132] == H_HEAD) first_cyc = cyc;
      n_asrt++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL spurious_flit: observed %0h expected no flit", out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        l = exp_last_q.pop_front();
        chk("flit", out_data, e);
        chk("tail_flags", {out_data_valid_wr, out_data_valid}, {l, l});
        if (l) void'(mdl_len_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_flit(input logic [133:0] d, input logic vwr, input logic v);
    in_data = d; in_data_wr = 1'b1; in_data_valid_wr = vwr; in_data_valid = v;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    in_data_wr = 1'b0; in_data_valid_wr = 1'b0; in_data_valid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit valid, input bit vwr, input bit has_tail, input bit ether);
    logic [133:0] f[$];
    logic [133:0] d;
    logic [1:0]   h;
    bit           is_tail;
    for (int i = 0; i < len; i++) begin
      is_tail = has_tail && (i == len - 1);
      h = (i == 0) ? H_HEAD : (is_tail ? H_TAIL : H_MID);
      d = {h, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
      if (ether && i == 1) d[31:16] = 16'h86dd;
      f.push_back(d);
    end
    for (int i = 0; i < len; i++) begin
      is_tail = has_tail && (i == len - 1);
      drive_flit(f[i], is_tail ? vwr : 1'b0, is_tail ? valid : 1'b0);
    end
    tail_cyc = cyc;
    if (has_tail && valid && vwr) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back(f[i]);
        exp_last_q.push_back(i == len - 1);
      end
      mdl_len_q.push_back(len);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rand_or = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    idle(3);
    chk(tag, 134'(exp_q.size()), 134'(0));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ready", in_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    mdl_len_q.delete();
  endtask

  initial begin
    int base_cnt;
    int r;
    rst = 1'b1; in_data_wr = 1'b0; in_data = '0; in_data_valid_wr = 1'b0;
    in_data_valid = 1'b0; out_ready = 1'b0;
`ifdef PKT_OUT_BUF_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_wr", out_data_wr, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_vwr", out_data_valid_wr, 1'b0);
    chk("rst_out_v", out_data_valid, 1'b0);
    rst = 1'b0;
    idle(2);

    // single 9-flit packet, latency from tail to first output flit
    out_ready = 1'b1;
    base_cnt = out_cnt;
    send_pkt(9, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("t1_drain");
    chk("t1_count", 134'(out_cnt - base_cnt), 134'(9));
    chk("t1_latency", 134'(first_cyc - tail_cyc), 134'(3));

    // dropped packets rewind to address 0; next valid packet starts there
    do_reset();
    base_cnt = out_cnt;
    send_pkt(9, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("t2_wr_ptr_rewind", dut.wr_ptr_q, '0);
    send_pkt(6, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("t2_no_vwr_rewind", dut.wr_ptr_q, '0);
    chk("t2_no_output", 134'(out_cnt - base_cnt), 134'(0));
    send_pkt(9, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_pkt_start", dut.pkt_start_q, '0);
    drain("t2_drain");
    chk("t2_count", 134'(out_cnt - base_cnt), 134'(9));
    chk("t2_wr_ptr", dut.wr_ptr_q, 134'(9));

    // fill with out_ready low until in_ready drops
    out_ready = 1'b0;
    base_cnt = out_cnt;
    for (int p = 1; p <= 18; p++) begin
      send_pkt(9, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2);
      chk($sformatf("t3_in_ready_p%0d", p), in_ready, exp_ready());
    end
    chk("t3_held", 134'(out_cnt - base_cnt), 134'(0));
    drain("t3_drain");
    chk("t3_count", 134'(out_cnt - base_cnt), 134'(162));
    chk("t3_in_ready_back", in_ready, exp_ready());

    // head without tail is abandoned by the next head
    base_cnt = out_cnt;
    send_pkt(4, 1'b1, 1'b1, 1'b0, 1'b0);
    send_pkt(9, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("t4_drain");
    chk("t4_count", 134'(out_cnt - base_cnt), 134'(9));

    // reset during SEND with a second packet still queued
    out_ready = 1'b1;
    send_pkt(40, 1'b1, 1'b1, 1'b1, 1'b0);
    send_pkt(10, 1'b1, 1'b1, 1'b1, 1'b0);
    r = 0;
    while (!out_data_wr && r < 50) begin
      @(posedge clk); #1;
      r++;
    end
    chk("t5_sending", out_data_wr, 1'b1);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_out_wr", out_data_wr, 1'b0);
    chk("t5_out_data", out_data, '0);
    chk("t5_out_vwr", out_data_valid_wr, 1'b0);
    chk("t5_out_v", out_data_valid, 1'b0);
    chk("t5_in_ready", in_ready, 1'b1);
    chk("t5_desc_count", dut.desc_count_q, '0);
    rst = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    mdl_len_q.delete();
    base_cnt = out_cnt;
    idle(60);
    chk("t5_quiet", 134'(out_cnt - base_cnt), 134'(0));

    // randomized traffic: lengths, drops, truncations, stray middles, out_ready
    rand_or = 1'b1;
    for (int p = 0; p < 30; p++) begin
      wait_ready();
      r = $urandom_range(0, 9);
      if (r == 0) drive_flit({H_MID, 4'h0, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      if (r == 1) send_pkt($urandom_range(2, 16), 1'b1, 1'b1, 1'b0, 1'b0);
      else        send_pkt($urandom_range(2, 16), r != 2, r != 3, 1'b1, 1'b0);
      idle($urandom_range(2, 4));
    end
    send_pkt(5, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("rand_drain");

`ifdef PKT_OUT_BUF_STAT_EN
    do_reset();
    out_ready = 1'b1;
    send_pkt(5, 1'b1, 1'b1, 1'b1, 1'b0);
    send_pkt(7, 1'b0, 1'b1, 1'b1, 1'b0);
    send_pkt(3, 1'b1, 1'b1, 1'b1, 1'b0);
    send_pkt(9, 1'b1, 1'b1, 1'b1, 1'b0);
    drain("stat_drain");
    chk("stat_rx", stat_rx_pkt, 134'(4));
    chk("stat_drop", stat_drop_pkt, 134'(1));
    chk("stat_tx", stat_tx_pkt, 134'(3));
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("stat_clr_rx", stat_rx_pkt, '0);
    chk("stat_clr_drop", stat_drop_pkt, '0);
    chk("stat_clr_tx", stat_tx_pkt, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
